// File: rtl/trap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// trap_sequencer_pkg : CSR commands/addresses, trap FSM states, mstatus fields
// Revision: 1.0
// ============================================================================
package trap_sequencer_pkg;

   typedef enum logic [2:0] {
      NONE       = 3'd0,
      READ_ONLY  = 3'd1,
      WRITE_ONLY = 3'd2,
      READ_WRITE = 3'd3,
      SET_BITS   = 3'd4,
      CLEAR_BITS = 3'd5
   } csr_command_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WR_EPC     = 3'd1,
      WR_CAUSE   = 3'd2,
      WR_TVAL    = 3'd3,
      WR_STATUS  = 3'd4,
      RET_STATUS = 3'd5,
      REDIRECT   = 3'd6
   } trap_state_t;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MSTATUS_MPP_LSB  = 11;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage
`default_nettype wire

// File: rtl/trap_sequencer_vector_calc.sv
`default_nettype none
// ============================================================================
// trap_vector_calc : trap target PC from mtvec (direct / vectored interrupts)
// Revision: 1.0
// ============================================================================
module trap_vector_calc
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int MXLEN   = 64,
   parameter int CAUSE_W = 6
) (
   input  logic [MXLEN-1:0]   mtvec_i,
   input  logic [CAUSE_W-1:0] cause_i,
   input  logic               is_interrupt_i,
   output logic [XLEN-1:0]    target_pc_o
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   assign base   = XLEN'({mtvec_i[MXLEN-1:2], 2'b00});
   assign offset = XLEN'({cause_i, 2'b00});

   // Reserved mode encodings fall back to direct mode
   always_comb begin
      target_pc_o = base;
      if (is_interrupt_i && (mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
         target_pc_o = base + offset;
      end
   end

endmodule
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// trap_sequencer : sequences trap/MRET CSR writes and PC redirect, else
//                  passes core CSR accesses through to the CSR write port
// Revision: 1.0
// ============================================================================
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int MXLEN   = 64,
   parameter int CAUSE_W = 6
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               exception_valid_i,
   input  logic [CAUSE_W-1:0] exception_cause_i,
   input  logic [XLEN-1:0]    exception_pc_i,
   input  logic [MXLEN-1:0]   exception_tval_i,
   input  logic               interrupt_valid_i,
   input  logic [CAUSE_W-1:0] interrupt_cause_i,
   input  logic [XLEN-1:0]    interrupt_pc_i,
   input  logic               mret_i,
   input  logic [MXLEN-1:0]   mstatus_i,
   input  logic [MXLEN-1:0]   mtvec_i,
   input  logic [MXLEN-1:0]   mepc_i,
   input  logic [11:0]        core_csr_address_i,
   input  csr_command_t       core_csr_command_i,
   input  logic [MXLEN-1:0]   core_csr_write_data_i,
   output logic               core_csr_stall_o,
   output logic [11:0]        csr_address_o,
   output csr_command_t       csr_command_o,
   output logic [MXLEN-1:0]   csr_write_data_o,
   output logic               busy_o,
   output logic               redirect_valid_o,
   output logic [XLEN-1:0]    redirect_pc_o
);

   trap_state_t        state_q, state_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [MXLEN-1:0]   tval_q, tval_d;
   logic               irq_q, irq_d;
   logic               mie_q, mie_d;
   logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

   logic               idle;
   logic               irq_enabled;
   logic               take_exc;
   logic               take_irq;
   logic               take_mret;
   logic               accept;
   logic               core_active;
   logic [XLEN-1:0]    trap_target;
   logic [MXLEN-1:0]   epc_word;
   logic [MXLEN-1:0]   cause_word;
   logic [MXLEN-1:0]   status_trap;
   logic [MXLEN-1:0]   status_ret;

   // Events are only considered in IDLE, one per cycle, highest priority wins
   assign idle        = (state_q == IDLE) && !reset_i;
   assign irq_enabled = interrupt_valid_i && mstatus_i[MSTATUS_MIE_BIT];
   assign take_exc    = idle && exception_valid_i;
   assign take_irq    = idle && !exception_valid_i && irq_enabled;
   assign take_mret   = idle && !exception_valid_i && !irq_enabled && mret_i;
   assign accept      = take_exc || take_irq || take_mret;
   assign core_active = (core_csr_command_i != NONE);

   assign epc_word   = MXLEN'({pc_q[XLEN-1:2], 2'b00});
   assign cause_word = {irq_q, (MXLEN-1)'(cause_q)};

   always_comb begin
      status_trap                              = mstatus_i;
      status_trap[MSTATUS_MPIE_BIT]            = mie_q;
      status_trap[MSTATUS_MIE_BIT]             = 1'b0;
      status_trap[MSTATUS_MPP_LSB +: 2]        = 2'b11;
      status_ret                               = mstatus_i;
      status_ret[MSTATUS_MIE_BIT]              = mstatus_i[MSTATUS_MPIE_BIT];
      status_ret[MSTATUS_MPIE_BIT]             = 1'b1;
      status_ret[MSTATUS_MPP_LSB +: 2]         = 2'b11;
   end

   trap_vector_calc #(
      .XLEN    (XLEN),
      .MXLEN   (MXLEN),
      .CAUSE_W (CAUSE_W)
   ) u_vector_calc (
      .mtvec_i        (mtvec_i),
      .cause_i        (cause_q),
      .is_interrupt_i (irq_q),
      .target_pc_o    (trap_target)
   );

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      cause_d          = cause_q;
      tval_d           = tval_q;
      irq_d            = irq_q;
      mie_d            = mie_q;
      redirect_pc_d    = redirect_pc_q;
      csr_address_o    = '0;
      csr_command_o    = NONE;
      csr_write_data_o = '0;
      busy_o           = (state_q != IDLE);
      core_csr_stall_o = (state_q != IDLE) && core_active;
      redirect_valid_o = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               busy_o           = 1'b1;
               core_csr_stall_o = core_active;
               mie_d            = mstatus_i[MSTATUS_MIE_BIT];
               irq_d            = take_irq;
               state_d          = take_mret ? RET_STATUS : WR_EPC;
               if (take_exc) begin
                  pc_d    = exception_pc_i;
                  cause_d = exception_cause_i;
                  tval_d  = exception_tval_i;
               end else if (take_irq) begin
                  pc_d    = interrupt_pc_i;
                  cause_d = interrupt_cause_i;
                  tval_d  = '0;
               end
            end else begin
               csr_address_o    = core_csr_address_i;
               csr_command_o    = core_csr_command_i;
               csr_write_data_o = core_csr_write_data_i;
            end
         end
         WR_EPC: begin
            csr_address_o    = CSR_MEPC;
            csr_command_o    = WRITE_ONLY;
            csr_write_data_o = epc_word;
            state_d          = WR_CAUSE;
         end
         WR_CAUSE: begin
            csr_address_o    = CSR_MCAUSE;
            csr_command_o    = WRITE_ONLY;
            csr_write_data_o = cause_word;
            state_d          = WR_TVAL;
         end
         WR_TVAL: begin
            csr_address_o    = CSR_MTVAL;
            csr_command_o    = WRITE_ONLY;
            csr_write_data_o = tval_q;
            state_d          = WR_STATUS;
         end
         WR_STATUS: begin
            csr_address_o    = CSR_MSTATUS;
            csr_command_o    = WRITE_ONLY;
            csr_write_data_o = status_trap;
            redirect_pc_d    = trap_target;
            state_d          = REDIRECT;
         end
         RET_STATUS: begin
            csr_address_o    = CSR_MSTATUS;
            csr_command_o    = WRITE_ONLY;
            csr_write_data_o = status_ret;
            redirect_pc_d    = XLEN'(mepc_i);
            state_d          = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid_o = 1'b1;
            state_d          = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A reset cycle must not leak a write or redirect from an aborted sequence
      if (reset_i) begin
         csr_address_o    = '0;
         csr_command_o    = NONE;
         csr_write_data_o = '0;
         busy_o           = 1'b0;
         core_csr_stall_o = 1'b0;
         redirect_valid_o = 1'b0;
      end
   end

   assign redirect_pc_o = redirect_pc_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         cause_q       <= '0;
         tval_q        <= '0;
         irq_q         <= 1'b0;
         mie_q         <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cause_q       <= cause_d;
         tval_q        <= tval_d;
         irq_q         <= irq_d;
         mie_q         <= mie_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Controller in front of the M-mode CSR file (exception_handler). It accepts synchronous exceptions, interrupts and MRET from the Lagarto Hun core, and drives the CSR file's single write port through a fixed multi-cycle save sequence: mepc, mcause, mtval, then mstatus. It then issues a one-cycle PC redirect to the trap vector (or to mepc for MRET). While idle, it passes the core's CSR-instruction accesses through to the same port, and stalls them while a sequence is running.

Parameters:
XLEN, 64, core PC/data width
MXLEN, 64, machine CSR width
CAUSE_W, 6, width of exception/interrupt cause code

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
exception_valid_i  in  1  core reports a synchronous exception this cycle
exception_cause_i  in  CAUSE_W  exception code
exception_pc_i  in  XLEN  PC of the faulting instruction
exception_tval_i  in  MXLEN  trap value (bad address/instruction, else 0)
interrupt_valid_i  in  1  level: an enabled interrupt is pending (mip & mie != 0)
interrupt_cause_i  in  CAUSE_W  highest-priority pending interrupt code
interrupt_pc_i  in  XLEN  PC of the next unretired instruction
mret_i  in  1  core retires MRET this cycle
mstatus_i  in  MXLEN  current mstatus from the CSR file
mtvec_i  in  MXLEN  current mtvec from the CSR file
mepc_i  in  MXLEN  current mepc from the CSR file
core_csr_address_i  in  12  core CSR-instruction address
core_csr_command_i  in  csr_command_t  core CSR-instruction command
core_csr_write_data_i  in  MXLEN  core CSR-instruction write data
core_csr_stall_o  out  1  core CSR access not accepted this cycle
csr_address_o  out  12  to CSR file
csr_command_o  out  csr_command_t  to CSR file
csr_write_data_o  out  MXLEN  to CSR file
busy_o  out  1  sequence in progress
redirect_valid_o  out  1  one-cycle pulse: fetch from redirect_pc_o
redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset: state IDLE; busy_o, redirect_valid_o and core_csr_stall_o = 0; redirect_pc_o = 0; csr_command_o = NONE; capture registers cleared. A reset asserted mid-sequence aborts it: no further writes and no redirect.
- Event acceptance in IDLE, by priority:
  - exception_valid_i wins.
  - Then interrupt_valid_i, taken only if mstatus_i[3] (MIE) = 1.
  - Then mret_i.
  - A lower-priority event that arrives in the same cycle is dropped. Interrupts are level-sensitive and are re-evaluated on the next return to IDLE.
  - Events are ignored while not in IDLE.
- On acceptance, capture pc, cause, tval and is_interrupt. Then: busy_o = 1 and core_csr_stall_o = 1 if a core command is not NONE; the core access is not forwarded.
- Trap FSM, one state per cycle, one CSR write per state with command WRITE_ONLY:
  - IDLE to WR_EPC: write mepc with captured pc, bits [1:0] forced to 0.
  - WR_EPC to WR_CAUSE: write mcause = {is_interrupt, zero-extend(cause)} with the interrupt flag in bit MXLEN-1.
  - WR_CAUSE to WR_TVAL: write mtval = captured tval; 0 for interrupts.
  - WR_TVAL to WR_STATUS: write mstatus with MPIE(7) taken from the MIE value sampled at acceptance, MIE(3) = 0, MPP(12:11) = 2'b11, all other bits from mstatus_i.
  - WR_STATUS to REDIRECT: redirect_valid_o = 1, no CSR write.
  - REDIRECT to IDLE.
- Trap latency: acceptance at cycle 0, writes in cycles 1–4, redirect in cycle 5, IDLE in cycle 6. busy_o is high in cycles 0–5.
- Trap vector: base = {mtvec_i[MXLEN-1:2], 2'b00}.
  - If mtvec_i[1:0] = 01 and the event is an interrupt: target = base + 4 * cause, modulo 2^XLEN.
  - Otherwise: target = base.
  - mtvec mode values 10 and 11 are treated as direct mode.
- MRET FSM:
  - IDLE to RET_STATUS: write mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11 (M-only core).
  - RET_STATUS to REDIRECT with redirect_pc_o = mepc_i.
  - REDIRECT to IDLE.
- Pass-through: in IDLE with no event accepted, csr_* outputs mirror the core_csr_* inputs combinationally and core_csr_stall_o = 0.
- Outside IDLE: core_csr_stall_o = 1 whenever the core command is not NONE.
- redirect_pc_o holds its last value outside REDIRECT.

Decomposition:
- riscv_privileged_pkg gains:
  - the trap_state_t enum (IDLE, WR_EPC, WR_CAUSE, WR_TVAL, WR_STATUS, RET_STATUS, REDIRECT)
  - constants MSTATUS_MIE_BIT = 3, MSTATUS_MPIE_BIT = 7, MSTATUS_MPP_LSB = 11
  - MTVEC_MODE_DIRECT and MTVEC_MODE_VECTORED
- CSR_* addresses and csr_command_t are reused from the existing packages.
- One sub-module, trap_vector_calc: combinational, takes mtvec, cause and is_interrupt, and produces the target PC.

Test Plan:
1. Exception: mtvec = 0x8000_0100, cause 2, pc 0x8000_0040, tval 0xDEAD → writes mepc = 0x8000_0040, mcause = 2, mtval = 0xDEAD, mstatus MIE 1→0 / MPIE = 1 in cycles 1–4; redirect 0x8000_0100 in cycle 5.
2. Vectored interrupt: mtvec = 0x8000_0101, cause 7, MIE = 1 → mcause = 0x8000_0000_0000_0007, mtval = 0; redirect 0x8000_011C.
3. Masked interrupt: interrupt_valid_i = 1 with MIE = 0 → no writes, busy_o = 0; set MIE = 1 → sequence starts on the next cycle.
4. Simultaneous exception, interrupt and mret → exception sequence only; after IDLE, the still-asserted interrupt is taken.
5. MRET: mstatus MPIE = 1, MIE = 0, mepc = 0x8000_0044 → mstatus MIE = 1, MPIE = 1; redirect 0x8000_0044 at cycle 2.
6. Core CSR write during a trap → core_csr_stall_o = 1 until IDLE, then passed through unchanged. Reset asserted at WR_CAUSE → IDLE next cycle, no redirect.
